// File: rtl/spi_master_frame.sv
// SPI mode-0 master that sends and receives one byte per frame, MSB first.
// Frame shape: LEAD, 8 sclk periods, TRAIL, then a cs_n-high GAP before IDLE.
module spi_master_frame #(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL,
    GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  state_t     r_state;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [2:0] r_bit;
  logic [7:0] r_div;
  logic [7:0] r_gap;
  logic       r_last;
  logic       w_div_end;

  assign w_div_end = (r_div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tx    <= '0;
      r_rx    <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_gap   <= '0;
      r_last  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_tx    <= tx_data;
            r_rx    <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_last  <= 1'b0;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            mosi    <= tx_data[7];
            r_state <= LEAD;
          end
        end

        LEAD: begin
          if (w_div_end) begin
            r_div   <= '0;
            sclk    <= 1'b1;
            r_rx    <= {r_rx[6:0], miso};
            r_state <= XFER;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end

        // The low phase following the 8th falling edge still belongs to XFER,
        // so cs_n stays low for LEAD + 16 half-periods + TRAIL.
        XFER: begin
          if (w_div_end) begin
            r_div <= '0;
            if (sclk) begin
              sclk  <= 1'b0;
              r_bit <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                r_last <= 1'b1;
              end else begin
                r_tx <= {r_tx[6:0], 1'b0};
                mosi <= r_tx[6];
              end
            end else if (r_last) begin
              r_last  <= 1'b0;
              r_state <= TRAIL;
            end else begin
              sclk <= 1'b1;
              r_rx <= {r_rx[6:0], miso};
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end

        TRAIL: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_gap   <= '0;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            rx_data <= r_rx;
            done    <= 1'b1;
            r_state <= GAP;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end

        GAP: begin
          if (r_gap == GAP_LAST) begin
            r_gap   <= '0;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap + 8'd1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_frame.sv
// Bench for spi_master_frame: two instances (CLK_DIV=2 and CLK_DIV=1) observed by
// a negedge frame monitor and a behavioural SPI slave.
module tb_spi_master_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start   [2];
  logic [7:0] tx_data [2];
  logic       busy    [2];
  logic       done    [2];
  logic [7:0] rx_data [2];
  logic       cs_n    [2];
  logic       sclk    [2];
  logic       mosi    [2];
  logic       miso    [2];

  bit         loopback [2];
  logic [7:0] slave_tx [2];
  logic [7:0] slave_sh [2] = '{8'h00, 8'h00};
  logic [7:0] slave_rx [2] = '{8'h00, 8'h00};
  logic       miso_s   [2] = '{1'b0, 1'b0};

  assign miso[0] = loopback[0] ? mosi[0] : miso_s[0];
  assign miso[1] = loopback[1] ? mosi[1] : miso_s[1];

  spi_master_frame #(.CLK_DIV(2), .GAP_CYC(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .tx_data(tx_data[0]),
    .busy(busy[0]), .done(done[0]), .rx_data(rx_data[0]), .cs_n(cs_n[0]),
    .sclk(sclk[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  spi_master_frame #(.CLK_DIV(1), .GAP_CYC(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .tx_data(tx_data[1]),
    .busy(busy[1]), .done(done[1]), .rx_data(rx_data[1]), .cs_n(cs_n[1]),
    .sclk(sclk[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  // Frame observations, one sample per clk cycle.
  logic       prev_cs   [2] = '{1'b1, 1'b1};
  logic       prev_sclk [2] = '{1'b0, 1'b0};
  int         low_cnt   [2] = '{0, 0};
  int         high_cnt  [2] = '{0, 0};
  int         last_low  [2] = '{0, 0};
  int         last_gap  [2] = '{0, 0};
  int         rises     [2] = '{0, 0};
  int         hrun      [2] = '{0, 0};
  int         lrun      [2] = '{0, 0};
  int         minh      [2] = '{255, 255};
  int         maxh      [2] = '{0, 0};
  int         minl      [2] = '{255, 255};
  int         maxl      [2] = '{0, 0};
  int         done_cnt  [2] = '{0, 0};
  int         frame_cnt [2] = '{0, 0};
  bit         mosi_one  [2] = '{1'b0, 1'b0};
  logic [7:0] rx_last   [2] = '{8'h00, 8'h00};
  logic [7:0] rx_prev   [2] = '{8'h00, 8'h00};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      prev_cs[d]   <= cs_n[d];
      prev_sclk[d] <= sclk[d];
      if (done[d]) begin
        done_cnt[d] <= done_cnt[d] + 1;
        rx_prev[d]  <= rx_last[d];
        rx_last[d]  <= rx_data[d];
      end
      if (!cs_n[d] && prev_cs[d]) begin
        frame_cnt[d] <= frame_cnt[d] + 1;
        last_gap[d]  <= high_cnt[d];
        low_cnt[d]   <= 1;
        rises[d]     <= 0;
        mosi_one[d]  <= mosi[d];
        minh[d] <= 255; maxh[d] <= 0; minl[d] <= 255; maxl[d] <= 0;
        slave_sh[d]  <= slave_tx[d];
        miso_s[d]    <= slave_tx[d][7];
      end else if (!cs_n[d]) begin
        low_cnt[d] <= low_cnt[d] + 1;
        if (mosi[d]) mosi_one[d] <= 1'b1;
      end else if (!prev_cs[d]) begin
        last_low[d] <= low_cnt[d];
        high_cnt[d] <= 1;
      end else begin
        high_cnt[d] <= high_cnt[d] + 1;
      end
      if (sclk[d] && !prev_sclk[d]) begin
        rises[d]    <= rises[d] + 1;
        hrun[d]     <= 1;
        slave_rx[d] <= {slave_rx[d][6:0], mosi[d]};
        if (rises[d] != 0) begin
          minl[d] <= (lrun[d] < minl[d]) ? lrun[d] : minl[d];
          maxl[d] <= (lrun[d] > maxl[d]) ? lrun[d] : maxl[d];
        end
      end else if (!sclk[d] && prev_sclk[d]) begin
        lrun[d]     <= 1;
        minh[d]     <= (hrun[d] < minh[d]) ? hrun[d] : minh[d];
        maxh[d]     <= (hrun[d] > maxh[d]) ? hrun[d] : maxh[d];
        slave_sh[d] <= slave_sh[d] << 1;
        miso_s[d]   <= slave_sh[d][6];
      end else if (sclk[d]) begin
        hrun[d] <= hrun[d] + 1;
      end else begin
        lrun[d] <= lrun[d] + 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic launch(input int d, input logic [7:0] tx);
    start[d]   = 1'b1;
    tx_data[d] = tx;
    @(negedge clk);
    start[d]   = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int target_done, output bit ok);
    int t = 0;
    while ((done_cnt[d] < target_done || busy[d]) && t < 400) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 400);
    @(negedge clk);
  endtask

  task automatic wait_rises(input int d, input int n, output bit ok);
    int t = 0;
    while (rises[d] < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 200);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; tx_data[d] = 8'h00; loopback[d] = 1'b1; slave_tx[d] = 8'h00;
    end
    wait_cycles(3);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({cs_n[d], sclk[d], mosi[d], busy[d], done[d], rx_data[d]} !== {5'b10000, 8'h00}) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: cs_n,sclk,mosi,busy,done,rx=%b%b%b%b%b %h required 10000 00",
                 d, cs_n[d], sclk[d], mosi[d], busy[d], done[d], rx_data[d]);
      end
    end
    rst = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_loopback();
    bit ok;
    int base = done_cnt[0];
    loopback[0] = 1'b1;
    launch(0, 8'hA5);
    n_checks++;
    if ({busy[0], cs_n[0], mosi[0]} !== 3'b101) begin
      n_fail++;
      $display("FAIL loop_start busy,cs_n,mosi=%b%b%b required 101", busy[0], cs_n[0], mosi[0]);
    end
    wait_idle(0, base + 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL loop_timeout: frame did not complete"); end
    n_checks++;
    if (rx_data[0] !== 8'hA5) begin n_fail++; $display("FAIL loop_rx got %h required a5", rx_data[0]); end
    n_checks++;
    if (last_low[0] !== 36) begin n_fail++; $display("FAIL loop_cs_low got %0d required 36", last_low[0]); end
    n_checks++;
    if (rises[0] !== 8) begin n_fail++; $display("FAIL loop_sclk_pulses got %0d required 8", rises[0]); end
    n_checks++;
    if (done_cnt[0] - base !== 1) begin n_fail++; $display("FAIL loop_done_count got %0d required 1", done_cnt[0] - base); end
    n_checks++;
    if ({minh[0], maxh[0], minl[0], maxl[0]} !== {32'd2, 32'd2, 32'd2, 32'd2}) begin
      n_fail++;
      $display("FAIL loop_sclk_phases high %0d..%0d low %0d..%0d required all 2", minh[0], maxh[0], minl[0], maxl[0]);
    end
  endtask

  task automatic test_slave();
    bit ok;
    int base = done_cnt[0];
    loopback[0] = 1'b0;
    slave_tx[0] = 8'hA9;
    launch(0, 8'h3C);
    wait_idle(0, base + 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL slave_timeout: frame did not complete"); end
    n_checks++;
    if (slave_rx[0] !== 8'h3C) begin n_fail++; $display("FAIL slave_captured got %h required 3c", slave_rx[0]); end
    n_checks++;
    if (rx_data[0] !== 8'hA9) begin n_fail++; $display("FAIL slave_rx got %h required a9", rx_data[0]); end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] tx, stx;
    for (int i = 0; i < 10; i++) begin
      int d = (i < 6) ? 0 : 1;
      int base = done_cnt[d];
      tx = 8'($urandom);
      stx = 8'($urandom);
      loopback[d] = 1'b0;
      slave_tx[d] = stx;
      launch(d, tx);
      wait_idle(d, base + 1, ok);
      n_checks++;
      if (!ok || rx_data[d] !== stx) begin
        n_fail++;
        $display("FAIL rand_rx dut%0d iter %0d got %h required %h (done=%0b)", d, i, rx_data[d], stx, ok);
      end
      n_checks++;
      if (slave_rx[d] !== tx) begin
        n_fail++;
        $display("FAIL rand_mosi dut%0d iter %0d slave got %h required %h", d, i, slave_rx[d], tx);
      end
      n_checks++;
      if (last_low[d] !== 18 * (2 - d)) begin
        n_fail++;
        $display("FAIL rand_cs_low dut%0d got %0d required %0d", d, last_low[d], 18 * (2 - d));
      end
    end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    int base_d = done_cnt[0];
    int base_f = frame_cnt[0];
    loopback[0] = 1'b1;
    launch(0, 8'h00);
    wait_rises(0, 2, ok);
    start[0]   = 1'b1;
    tx_data[0] = 8'hFF;
    @(negedge clk);
    start[0]   = 1'b0;
    wait_idle(0, base_d + 1, ok);
    wait_cycles(10);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ignore_timeout: frame did not complete"); end
    n_checks++;
    if (mosi_one[0] !== 1'b0) begin n_fail++; $display("FAIL ignore_mosi got mosi high during frame, required low"); end
    n_checks++;
    if (done_cnt[0] - base_d !== 1) begin n_fail++; $display("FAIL ignore_done got %0d pulses required 1", done_cnt[0] - base_d); end
    n_checks++;
    if (frame_cnt[0] - base_f !== 1) begin n_fail++; $display("FAIL ignore_frames got %0d required 1", frame_cnt[0] - base_f); end
    n_checks++;
    if (rx_data[0] !== 8'h00) begin n_fail++; $display("FAIL ignore_rx got %h required 00", rx_data[0]); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t = 0;
    int base_d = done_cnt[0];
    int base_f = frame_cnt[0];
    loopback[0] = 1'b1;
    start[0]   = 1'b1;
    tx_data[0] = 8'h01;
    @(negedge clk);
    tx_data[0] = 8'h80;
    while (frame_cnt[0] < base_f + 2 && t < 400) begin
      @(negedge clk);
      t++;
    end
    start[0] = 1'b0;
    wait_idle(0, base_d + 2, ok);
    n_checks++;
    if (!ok || t >= 400) begin n_fail++; $display("FAIL b2b_timeout: second frame did not complete"); end
    n_checks++;
    if (last_gap[0] !== 3) begin n_fail++; $display("FAIL b2b_gap got %0d cs_n-high cycles required 3", last_gap[0]); end
    n_checks++;
    if ({rx_prev[0], rx_last[0]} !== 16'h0180) begin
      n_fail++;
      $display("FAIL b2b_rx got %h then %h required 01 then 80", rx_prev[0], rx_last[0]);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int base;
    loopback[0] = 1'b0;
    slave_tx[0] = 8'h5B;
    launch(0, 8'hC3);
    wait_rises(0, 3, ok);
    base = done_cnt[0];
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({cs_n[0], sclk[0], mosi[0], busy[0], rx_data[0]} !== {4'b1000, 8'h00}) begin
      n_fail++;
      $display("FAIL midrst_async cs_n,sclk,mosi,busy,rx=%b%b%b%b %h required 1000 00",
               cs_n[0], sclk[0], mosi[0], busy[0], rx_data[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(6);
    n_checks++;
    if (!ok || done_cnt[0] !== base) begin
      n_fail++;
      $display("FAIL midrst_no_done got %0d pulses required 0 (reached 3 rises=%0b)", done_cnt[0] - base, ok);
    end
    base = done_cnt[0];
    slave_tx[0] = 8'h6E;
    launch(0, 8'h91);
    wait_idle(0, base + 1, ok);
    n_checks++;
    if (!ok || rx_data[0] !== 8'h6E || slave_rx[0] !== 8'h91) begin
      n_fail++;
      $display("FAIL midrst_next rx %h slave %h required 6e and 91", rx_data[0], slave_rx[0]);
    end
  endtask

  task automatic test_div1();
    bit ok;
    int base = done_cnt[1];
    loopback[1] = 1'b1;
    launch(1, 8'h5A);
    wait_idle(1, base + 1, ok);
    n_checks++;
    if (!ok || rx_data[1] !== 8'h5A) begin n_fail++; $display("FAIL div1_rx got %h required 5a", rx_data[1]); end
    n_checks++;
    if (last_low[1] !== 18) begin n_fail++; $display("FAIL div1_cs_low got %0d required 18", last_low[1]); end
    n_checks++;
    if (rises[1] !== 8) begin n_fail++; $display("FAIL div1_sclk_pulses got %0d required 8", rises[1]); end
    n_checks++;
    if ({minh[1], maxh[1], minl[1], maxl[1]} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      n_fail++;
      $display("FAIL div1_sclk_phases high %0d..%0d low %0d..%0d required all 1", minh[1], maxh[1], minl[1], maxl[1]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_div1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
